// File: rtl/fft_stage_tm_pkg.sv
// Shared types and helpers for the time-multiplexed radix-2 FFT stage.
package fft_stage_tm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Counter width that stays at least one bit for degenerate counts.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fft_stage_tm_bf_core.sv
// One pipelined radix-2 butterfly (3-multiplier twiddle product) with
// per-result scaling or saturation; valid, pair index and data travel together.
module fft_stage_tm_bf_core
    import fft_stage_tm_pkg::*;
#(
    parameter int unsigned DW     = 8,
    parameter int unsigned TW     = 8,
    parameter int unsigned BF_LAT = 3,
    parameter int unsigned IW     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [IW-1:0]        in_idx,
    input  logic                 scale_en,
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    input  logic signed [TW-1:0] c,
    input  logic signed [TW:0]   cps,
    input  logic signed [TW:0]   cms,
    output logic                 out_valid,
    output logic [IW-1:0]        out_idx,
    output logic [2*DW-1:0]      out_d,
    output logic [2*DW-1:0]      out_e,
    output logic                 out_ovf
);
    localparam int unsigned XW = DW + 1;
    localparam int unsigned PW = DW + TW + 2;
    localparam int unsigned RW = IW + 4*DW + 1;

    logic signed [XW-1:0] bdiff, pr, pi, a_re_x, a_im_x;
    logic signed [PW-1:0] z, bi_cps, br_cms;
    logic [DW:0]          fdr, fdi, fer, fei;
    logic [RW-1:0]        res;

    logic [BF_LAT-1:0]         vld;
    logic [BF_LAT-1:0][RW-1:0] dat;

    // {clip flag, result}: floor halving when scaling, otherwise clamp to DW bits.
    function automatic logic [DW:0] fit(input logic signed [XW-1:0] s, input logic sc);
        logic [DW:0] r;
        if (sc)
            r = {1'b0, s[DW:1]};
        else if (s[DW] != s[DW-1])
            r = {1'b1, s[DW], {(DW-1){~s[DW]}}};
        else
            r = {1'b0, s[DW-1:0]};
        return r;
    endfunction

    assign bdiff  = XW'(b_re) - XW'(b_im);
    assign z      = PW'(c) * PW'(bdiff);
    assign bi_cps = PW'(b_im) * PW'(cps);
    assign br_cms = PW'(b_re) * PW'(cms);
    assign pr     = XW'((z + bi_cps) >>> (TW-1));
    assign pi     = XW'((br_cms - z) >>> (TW-1));
    assign a_re_x = XW'(a_re);
    assign a_im_x = XW'(a_im);

    assign fdr = fit(a_re_x + pr, scale_en);
    assign fdi = fit(a_im_x + pi, scale_en);
    assign fer = fit(a_re_x - pr, scale_en);
    assign fei = fit(a_im_x - pi, scale_en);

    assign res = {in_idx, fdr[DW] | fdi[DW] | fer[DW] | fei[DW],
                  fei[DW-1:0], fer[DW-1:0], fdi[DW-1:0], fdr[DW-1:0]};

    // Delay line; synthesis retiming spreads the arithmetic across the stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            dat <= '0;
        end else begin
            vld[0] <= in_valid;
            dat[0] <= res;
            for (int unsigned k = 1; k < BF_LAT; k++) begin
                vld[k] <= vld[k-1];
                dat[k] <= dat[k-1];
            end
        end
    end

    assign out_valid = vld[BF_LAT-1];
    assign out_d     = dat[BF_LAT-1][2*DW-1:0];
    assign out_e     = dat[BF_LAT-1][4*DW-1:2*DW];
    assign out_ovf   = dat[BF_LAT-1][4*DW];
    assign out_idx   = dat[BF_LAT-1][RW-1:4*DW+1];

endmodule

// File: rtl/fft_stage_tm.sv
// Time-multiplexed radix-2 FFT stage: snapshots a frame, feeds PAR butterfly
// cores one group of pairs per cycle, and writes results back in place.
module fft_stage_tm
    import fft_stage_tm_pkg::*;
#(
    parameter int unsigned N      = 16,
    parameter int unsigned DW     = 8,
    parameter int unsigned TW     = 8,
    parameter int unsigned PAR    = 2,
    parameter int unsigned BF_LAT = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_calc,
    input  logic                    scale_en,
    input  logic [N*2*DW-1:0]       input_regs,
    input  logic [N/2*TW-1:0]       c_regs,
    input  logic [N/2*(TW+1)-1:0]   cps_regs,
    input  logic [N/2*(TW+1)-1:0]   cms_regs,
    output logic [N*2*DW-1:0]       output_data,
    output logic                    data_valid,
    output logic                    busy,
    output logic                    overflow
);
    localparam int unsigned H   = N / 2;
    localparam int unsigned G   = H / PAR;
    localparam int unsigned EW  = 2 * DW;
    localparam int unsigned SW  = TW + 1;
    localparam int unsigned GW  = cnt_w(G);
    localparam int unsigned DRW = cnt_w(BF_LAT);
    localparam int unsigned IW  = cnt_w(H);

    state_t         state, state_nx;
    logic [GW-1:0]  grp, grp_nx;
    logic [DRW-1:0] dcnt, dcnt_nx;
    logic           issue, accept;

    logic [N*2*DW-1:0]     snap_in;
    logic [H*TW-1:0]       snap_c;
    logic [H*SW-1:0]       snap_cps, snap_cms;
    logic                  snap_scale;

    logic [PAR-1:0]  bv, bo;
    logic [IW-1:0]   bidx [PAR];
    logic [EW-1:0]   bd [PAR];
    logic [EW-1:0]   be [PAR];

    assign accept = (state == ST_IDLE) && start_calc;

    always_comb begin
        state_nx = state;
        grp_nx   = grp;
        dcnt_nx  = dcnt;
        issue    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_calc) begin
                    state_nx = ST_ISSUE;
                    grp_nx   = '0;
                end
            end
            ST_ISSUE: begin
                issue = 1'b1;
                if (grp == GW'(G - 1)) begin
                    state_nx = ST_DRAIN;
                    dcnt_nx  = '0;
                end else begin
                    grp_nx = grp + GW'(1);
                end
            end
            ST_DRAIN: begin
                if (dcnt == DRW'(BF_LAT - 1))
                    state_nx = ST_DONE;
                else
                    dcnt_nx = dcnt + DRW'(1);
            end
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // busy covers the data_valid cycle, which follows the DONE state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            grp        <= '0;
            dcnt       <= '0;
            busy       <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            state      <= state_nx;
            grp        <= grp_nx;
            dcnt       <= dcnt_nx;
            busy       <= (state_nx != ST_IDLE) || (state == ST_DONE);
            data_valid <= (state == ST_DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_in    <= '0;
            snap_c     <= '0;
            snap_cps   <= '0;
            snap_cms   <= '0;
            snap_scale <= 1'b0;
        end else if (accept) begin
            snap_in    <= input_regs;
            snap_c     <= c_regs;
            snap_cps   <= cps_regs;
            snap_cms   <= cms_regs;
            snap_scale <= scale_en;
        end
    end

    for (genvar p = 0; p < PAR; p++) begin : g_core
        logic [IW-1:0] pidx;
        assign pidx = IW'(32'(grp) * PAR + 32'(p));

        fft_stage_tm_bf_core #(
            .DW     (DW),
            .TW     (TW),
            .BF_LAT (BF_LAT),
            .IW     (IW)
        ) u_bf (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (issue),
            .in_idx    (pidx),
            .scale_en  (snap_scale),
            .a_re      (snap_in[pidx*EW +: DW]),
            .a_im      (snap_in[pidx*EW + DW +: DW]),
            .b_re      (snap_in[(pidx + H)*EW +: DW]),
            .b_im      (snap_in[(pidx + H)*EW + DW +: DW]),
            .c         (snap_c[pidx*TW +: TW]),
            .cps       (snap_cps[pidx*SW +: SW]),
            .cms       (snap_cms[pidx*SW +: SW]),
            .out_valid (bv[p]),
            .out_idx   (bidx[p]),
            .out_d     (bd[p]),
            .out_e     (be[p]),
            .out_ovf   (bo[p])
        );
    end

    // Write-back demux: D to slot i, E to slot i+N/2; overflow is sticky per frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            output_data <= '0;
            overflow    <= 1'b0;
        end else begin
            if (accept)
                overflow <= 1'b0;
            for (int p = 0; p < PAR; p++) begin
                if (bv[p]) begin
                    output_data[bidx[p]*EW +: EW]       <= bd[p];
                    output_data[(bidx[p] + H)*EW +: EW] <= be[p];
                    if (bo[p])
                        overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_stage_tm.sv
// Directed and randomized checks of fft_stage_tm against an integer reference model.
module tb_fft_stage_tm;
    localparam int N = 16, DW = 8, TW = 8, PAR = 2, BF_LAT = 3;
    localparam int H = N / 2, G = H / PAR, L = G + BF_LAT + 1;
    localparam int VW = N * 2 * DW, CW = H * TW, TW1 = TW + 1, SW = H * TW1;
    localparam int MX = (1 << (DW - 1)) - 1, MN = -(1 << (DW - 1));

    logic          clk = 1'b0, rst = 1'b1;
    logic          start_calc, scale_en;
    logic [VW-1:0] input_regs;
    logic [CW-1:0] c_regs;
    logic [SW-1:0] cps_regs, cms_regs;
    logic [VW-1:0] output_data;
    logic          data_valid, busy, overflow;

    int far[N], fai[N], fc[H], fcps[H], fcms[H];
    bit fscale;
    logic [VW-1:0] exp_v;
    logic          exp_ov;
    int total = 0, bad = 0;

    fft_stage_tm #(.N(N), .DW(DW), .TW(TW), .PAR(PAR), .BF_LAT(BF_LAT)) dut (
        .clk(clk), .rst(rst), .start_calc(start_calc), .scale_en(scale_en),
        .input_regs(input_regs), .c_regs(c_regs), .cps_regs(cps_regs), .cms_regs(cms_regs),
        .output_data(output_data), .data_valid(data_valid), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, expv);
        end
    endtask

    task automatic chk_el(input string tag, input int slot, input int im, input int val);
        logic [DW-1:0] g, e;
        g = output_data[slot*2*DW + im*DW +: DW];
        e = DW'(val);
        chk(tag, VW'(g), VW'(e));
    endtask

    function automatic int fitv(input int s, input bit sc);
        if (sc) return s >>> 1;
        if (s > MX) return MX;
        if (s < MN) return MN;
        return s;
    endfunction

    function automatic int rnd90();
        return int'($urandom_range(180)) - 90;
    endfunction

    // Reference: W = C - jS, P = B*W scaled by 2^-(TW-1), D = A + P, E = A - P.
    task automatic build_expect();
        exp_v  = '0;
        exp_ov = 1'b0;
        for (int i = 0; i < H; i++) begin
            int br, bi, z, pr, pim;
            int s[4];
            br  = far[i + H];
            bi  = fai[i + H];
            z   = fc[i] * (br - bi);
            pr  = (z + bi * fcps[i]) >>> (TW - 1);
            pim = (br * fcms[i] - z) >>> (TW - 1);
            s[0] = far[i] + pr;  s[1] = fai[i] + pim;
            s[2] = far[i] - pr;  s[3] = fai[i] - pim;
            for (int q = 0; q < 4; q++)
                if (!fscale && (s[q] > MX || s[q] < MN)) exp_ov = 1'b1;
            exp_v[i*2*DW +: DW]          = DW'(fitv(s[0], fscale));
            exp_v[i*2*DW + DW +: DW]     = DW'(fitv(s[1], fscale));
            exp_v[(i+H)*2*DW +: DW]      = DW'(fitv(s[2], fscale));
            exp_v[(i+H)*2*DW + DW +: DW] = DW'(fitv(s[3], fscale));
        end
    endtask

    task automatic drive_ports();
        for (int k = 0; k < N; k++) begin
            input_regs[k*2*DW +: DW]      = DW'(far[k]);
            input_regs[k*2*DW + DW +: DW] = DW'(fai[k]);
        end
        for (int i = 0; i < H; i++) begin
            c_regs[i*TW +: TW]     = TW'(fc[i]);
            cps_regs[i*TW1 +: TW1] = TW1'(fcps[i]);
            cms_regs[i*TW1 +: TW1] = TW1'(fcms[i]);
        end
        scale_en = fscale;
    endtask

    task automatic scramble();
        for (int k = 0; k < VW / 32; k++) input_regs[k*32 +: 32] = $urandom;
        c_regs   = CW'({$urandom, $urandom});
        cps_regs = SW'({$urandom, $urandom, $urandom});
        cms_regs = SW'({$urandom, $urandom, $urandom});
        scale_en = ~scale_en;
    endtask

    task automatic set_uniform(input int ar, input int ai, input int br, input int bi,
                               input int c, input int cps, input int cms, input bit sc);
        for (int k = 0; k < H; k++) begin
            far[k] = ar;  fai[k] = ai;
            far[k+H] = br; fai[k+H] = bi;
            fc[k] = c; fcps[k] = cps; fcms[k] = cms;
        end
        fscale = sc;
    endtask

    task automatic set_random();
        for (int k = 0; k < N; k++) begin
            far[k] = rnd90();
            fai[k] = rnd90();
        end
        for (int i = 0; i < H; i++) begin
            int c, s;
            c = rnd90();
            s = rnd90();
            fc[i] = c; fcps[i] = c + s; fcms[i] = c - s;
        end
        fscale = bit'($urandom_range(1));
    endtask

    // One frame from an idle DUT; optionally pokes start_calc while busy.
    task automatic run_frame(input string tag, input bit poke);
        int lat;
        bit busy_ok;
        build_expect();
        drive_ports();
        start_calc = 1'b1;
        @(negedge clk);
        start_calc = 1'b0;
        scramble();
        chk({tag, ".busy_on"}, VW'(busy), VW'(1'b1));
        lat = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 4 * L; k++) begin
            @(negedge clk);
            if (data_valid) begin
                lat = k;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            start_calc = poke && (k == 3 || k == L - 1);
        end
        start_calc = 1'b0;
        chk({tag, ".latency"}, VW'(lat), VW'(L));
        chk({tag, ".busy_held"}, VW'(busy_ok), VW'(1'b1));
        chk({tag, ".busy_dv"}, VW'(busy), VW'(1'b1));
        chk({tag, ".data"}, output_data, exp_v);
        chk({tag, ".ovf"}, VW'(overflow), VW'(exp_ov));
        @(negedge clk);
        chk({tag, ".dv_pulse"}, VW'(data_valid), VW'(1'b0));
        chk({tag, ".busy_off"}, VW'(busy), VW'(1'b0));
        chk({tag, ".data_hold"}, output_data, exp_v);
    endtask

    initial begin
        int first, gap, cnt;
        bit drop;
        start_calc = 1'b0;
        scale_en   = 1'b0;
        input_regs = '0;
        c_regs     = '0;
        cps_regs   = '0;
        cms_regs   = '0;

        repeat (3) @(negedge clk);
        chk("rst.data", output_data, '0);
        chk("rst.dv", VW'(data_valid), VW'(1'b0));
        chk("rst.busy", VW'(busy), VW'(1'b0));
        chk("rst.ovf", VW'(overflow), VW'(1'b0));
        rst = 1'b0;
        @(negedge clk);

        set_uniform(10, 0, 20, 0, 127, 127, 127, 1'b0);
        run_frame("unity", 1'b0);
        chk_el("unity.d_re", 0, 0, 29);
        chk_el("unity.d_im", 0, 1, 0);
        chk_el("unity.e_re", H, 0, -9);
        chk_el("unity.e_im", H + 3, 1, 0);

        set_uniform(10, 0, 20, 0, 127, 127, 127, 1'b1);
        run_frame("unity_sc", 1'b0);
        chk_el("unity_sc.d_re", 2, 0, 14);
        chk_el("unity_sc.e_re", H + 1, 0, -5);

        set_uniform(127, 0, 127, 0, 127, 127, 127, 1'b0);
        run_frame("sat", 1'b0);
        chk_el("sat.d_re", 0, 0, 127);
        chk("sat.ovf_set", VW'(overflow), VW'(1'b1));

        set_uniform(127, 0, 127, 0, 127, 127, 127, 1'b1);
        run_frame("sat_sc", 1'b0);
        chk_el("sat_sc.d_re", 0, 0, 126);
        chk("sat_sc.ovf_clr", VW'(overflow), VW'(1'b0));

        set_uniform(5, 5, 20, 0, 0, 127, -127, 1'b0);
        run_frame("negj", 1'b1);
        chk_el("negj.d_re", 1, 0, 5);
        chk_el("negj.d_im", 1, 1, -15);
        chk_el("negj.e_re", H + 1, 0, 5);
        chk_el("negj.e_im", H + 1, 1, 25);

        for (int r = 0; r < 8; r++) begin
            set_random();
            run_frame($sformatf("rand%0d", r), bit'(r % 2));
        end

        // start_calc held high: back-to-back frames, then reset mid-frame.
        set_uniform(10, 0, 20, 0, 127, 127, 127, 1'b0);
        build_expect();
        drive_ports();
        start_calc = 1'b1;
        first = 0;
        for (int k = 1; k <= 4 * L; k++) begin
            @(negedge clk);
            if (data_valid) begin
                first = k;
                break;
            end
        end
        chk("hold.first", VW'(first), VW'(L + 1));
        gap = 0;
        drop = 1'b0;
        for (int k = 1; k <= 4 * L; k++) begin
            @(negedge clk);
            if (!busy) drop = 1'b1;
            if (data_valid) begin
                gap = k;
                break;
            end
        end
        chk("hold.period", VW'(gap), VW'(L + 1));
        chk("hold.busy_cont", VW'(drop), VW'(1'b0));
        chk("hold.data", output_data, exp_v);
        @(negedge clk);
        chk("hold.restart", VW'(busy), VW'(1'b1));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst.busy", VW'(busy), VW'(1'b0));
        chk("midrst.dv", VW'(data_valid), VW'(1'b0));
        chk("midrst.data", output_data, '0);
        chk("midrst.ovf", VW'(overflow), VW'(1'b0));
        start_calc = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (3 * L) begin
            @(negedge clk);
            if (data_valid) cnt++;
        end
        chk("midrst.no_dv", VW'(cnt), VW'(0));
        chk("midrst.idle", VW'(busy), VW'(1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
